sdp_triosy_multi_wait_dp: RTL and testbench
===========================================

Name: sdp_triosy_multi_wait_dp

Overview:
- Parametrised, multi-channel successor to the single-bit triosy wait datapath used in SDP core handshakes.
- Each channel turns a producer event pulse (biwt) and a consumer take strobe (bdwt) into a held-available flag (bawt).
- Adds a per-channel data payload, a configurable pending depth (queue) or a merge mode, overflow detection and an all-channels-available aggregate.
- Sits between the HLS core FSM and SDP config/status triosy objects.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- DATA_W, 8: payload width per channel (>=1).
- DEPTH, 2: max pending events per channel in QUEUE mode (>=1). Ignored in MERGE mode, where the effective depth is 1.
- MODE, 0: 0 = QUEUE (events kept in order); 1 = MERGE (single hold, latest payload wins; the original one-bit behaviour).

Ports:
- nvdla_core_clk  in  1  core clock, all state on rising edge.
- nvdla_core_rst  in  1  reset, asynchronous assert, active-high.
- biwt  in  NUM_CH  per-channel event-in pulse.
- bdwt  in  NUM_CH  per-channel take strobe from consumer.
- din  in  NUM_CH*DATA_W  payload accompanying biwt; channel i occupies bits [i*DATA_W +: DATA_W].
- ovf_clr  in  NUM_CH  clears the sticky overflow flag.
- bawt  out  NUM_CH  channel available (event present now or pending).
- dout  out  NUM_CH*DATA_W  payload of the currently available event.
- pend_cnt  out  NUM_CH*CW  stored-event count per channel, where CW = $clog2(DEPTH+1).
- ovf  out  NUM_CH  sticky overflow flag (event lost).
- all_bawt  out  1  AND of all bawt bits.

Behaviour:
- Reset (async, while nvdla_core_rst=1): all counts, read/write pointers, storage, ovf cleared to 0.
  - Consequently bawt = biwt, dout = din, all_bawt = &biwt.
- Per channel: consume = bdwt & bawt. bdwt is ignored when bawt=0.
- bawt = biwt | (cnt != 0). This is combinational, zero latency.

QUEUE mode (MODE=0):
- cnt=0 (empty):
  - dout = din (bypass).
  - biwt & consume: nothing stored, cnt stays 0.
  - biwt & ~consume: push din, cnt becomes 1.
- cnt>0:
  - dout = storage[rd_ptr] (oldest).
  - consume: pop, rd_ptr advances.
  - biwt: push din at wr_ptr, wr_ptr advances.
  - Simultaneous push and pop: cnt unchanged.
- Full (cnt=DEPTH):
  - biwt & ~consume: din dropped, cnt stays DEPTH, ovf set next cycle.
  - biwt & consume: pop and push both happen, no overflow.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- DEPTH=1 with no biwt while full gives exactly next_cnt = bawt & ~bdwt.

MERGE mode (MODE=1):
- One valid bit v plus one payload register.
- v_next = bawt & ~bdwt.
- Payload register loads din whenever biwt=1; otherwise it holds.
- dout = biwt ? din : register.
- ovf set when v=1 & biwt=1 & bdwt=0 (a pending event was merged away).
- pend_cnt = v.

Common to both modes:
- ovf: set has priority over same-cycle ovf_clr. ovf_clr clears on the next edge.
- Channels are fully independent; no cross-channel ordering.
- Reset mid-operation discards all pending events without raising ovf.
- No combinational path from any output back to an input of the same channel other than biwt/din to bawt/dout (bypass).

Test Plan:
- Reset, NUM_CH=4, DEPTH=2, QUEUE: release reset, biwt=0 -> bawt=0, all_bawt=0, pend_cnt=0, ovf=0. Assert reset mid-queue with cnt=2 -> cnt=0, bawt=0 immediately, ovf=0.
- Bypass: ch0 biwt=1, din=0x5A, bdwt=1 in the same cycle -> bawt[0]=1, dout=0x5A that cycle, cnt stays 0 the next cycle.
- Queue order and full: ch1 pushes 0x11, 0x22 with bdwt=0 -> cnt=2. Third push 0x33 -> dropped, ovf[1]=1. Then take twice -> dout 0x11 then 0x22, cnt back to 0. ovf_clr -> ovf[1]=0.
- Full plus simultaneous push/take: ch2 full (0xA0, 0xA1), biwt=1 din=0xA2 with bdwt=1 -> dout=0xA0, cnt stays 2, next heads 0xA1 then 0xA2, ovf=0.
- MERGE mode: event 0x01 with no take, then event 0x02 with no take -> v=1, dout=0x02, ovf=1. Take -> v=0. ovf_clr and a new merge event in the same cycle -> ovf stays 1.
- Aggregate: events on channels 0-2 only -> all_bawt=0. Add channel 3 -> all_bawt=1 in the same cycle.

Source files
------------

// File: rtl/sdp_triosy_multi_wait_dp_if.sv
// Handshake bundle for the multi-channel triosy wait datapath.
// The master side drives the event, take and payload lanes; the slave side reports availability.
interface sdp_triosy_multi_wait_dp_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]        biwt;
  logic [NUM_CH-1:0]        bdwt;
  logic [NUM_CH*DATA_W-1:0] din;
  logic [NUM_CH-1:0]        ovf_clr;
  logic [NUM_CH-1:0]        bawt;
  logic [NUM_CH*DATA_W-1:0] dout;
  logic [NUM_CH*CW-1:0]     pend_cnt;
  logic [NUM_CH-1:0]        ovf;
  logic                     all_bawt;

  modport master (
    output biwt, bdwt, din, ovf_clr,
    input  bawt, dout, pend_cnt, ovf, all_bawt
  );

  modport slave (
    input  biwt, bdwt, din, ovf_clr,
    output bawt, dout, pend_cnt, ovf, all_bawt
  );
endinterface

// File: rtl/sdp_triosy_multi_wait_dp.sv
// Multi-channel triosy wait datapath: each channel holds producer events until the consumer takes them,
// either as an ordered queue (MODE=0) or as a single latest-wins hold (MODE=1).
module sdp_triosy_multi_wait_dp #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0
) (
  input logic                       nvdla_core_clk,
  input logic                       nvdla_core_rst,
  sdp_triosy_multi_wait_dp_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_CH-1:0]        bawt_w;
  logic [NUM_CH-1:0]        ovf_w;
  logic [NUM_CH*DATA_W-1:0] dout_w;
  logic [NUM_CH*CW-1:0]     cnt_w;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic              biwt_c;
    logic              bdwt_c;
    logic              clr_c;
    logic [DATA_W-1:0] din_c;
    logic              ovf_set;
    logic              ovf_q;
    logic              ovf_d;

    assign biwt_c = bus.biwt[i];
    assign bdwt_c = bus.bdwt[i];
    assign clr_c  = bus.ovf_clr[i];
    assign din_c  = bus.din[i*DATA_W +: DATA_W];

    if (MODE == 0) begin : g_queue
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [CW-1:0]     cnt_q;
      logic [CW-1:0]     cnt_d;
      logic [PW-1:0]     rd_q;
      logic [PW-1:0]     wr_q;
      logic              empty;
      logic              full;
      logic              consume;
      logic              push;
      logic              pop;

      assign empty   = (cnt_q == '0);
      assign full    = (cnt_q == CW'(DEPTH));
      assign bawt_w[i] = biwt_c | ~empty;
      assign consume = bdwt_c & bawt_w[i];
      // An event taken in its own arrival cycle bypasses storage; a full queue drops unless it also pops.
      assign pop     = consume & ~empty;
      assign push    = biwt_c & ~(empty & consume) & ~(full & ~consume);
      assign ovf_set = biwt_c & full & ~consume;
      assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

      assign dout_w[i*DATA_W +: DATA_W] = empty ? din_c : mem_q[rd_q];
      assign cnt_w[i*CW +: CW]          = cnt_q;

      always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
          cnt_q <= '0;
          rd_q  <= '0;
          wr_q  <= '0;
          for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
          cnt_q <= cnt_d;
          if (pop)  rd_q <= ptr_inc(rd_q);
          if (push) begin
            wr_q        <= ptr_inc(wr_q);
            mem_q[wr_q] <= din_c;
          end
        end
      end
    end else begin : g_merge
      logic              v_q;
      logic              v_d;
      logic [DATA_W-1:0] pay_q;

      assign bawt_w[i] = biwt_c | v_q;
      assign v_d       = bawt_w[i] & ~bdwt_c;
      assign ovf_set   = v_q & biwt_c & ~bdwt_c;

      assign dout_w[i*DATA_W +: DATA_W] = biwt_c ? din_c : pay_q;
      assign cnt_w[i*CW +: CW]          = CW'(v_q);

      always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
          v_q   <= 1'b0;
          pay_q <= '0;
        end else begin
          v_q <= v_d;
          if (biwt_c) pay_q <= din_c;
        end
      end
    end

    // A lost event outranks a same-cycle clear so the loss is never hidden.
    assign ovf_d    = ovf_set ? 1'b1 : (clr_c ? 1'b0 : ovf_q);
    assign ovf_w[i] = ovf_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) ovf_q <= 1'b0;
      else                ovf_q <= ovf_d;
    end
  end

  assign bus.bawt     = bawt_w;
  assign bus.dout     = dout_w;
  assign bus.pend_cnt = cnt_w;
  assign bus.ovf      = ovf_w;
  assign bus.all_bawt = &bawt_w;
endmodule

// File: tb/tb_sdp_triosy_multi_wait_dp.sv
// Directed bench for sdp_triosy_multi_wait_dp: a QUEUE instance (4 ch, depth 2) and a MERGE instance (2 ch).
module tb_sdp_triosy_multi_wait_dp;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sdp_triosy_multi_wait_dp_if #(.NUM_CH(4), .DATA_W(8), .DEPTH(2)) q_if ();
  sdp_triosy_multi_wait_dp_if #(.NUM_CH(2), .DATA_W(8), .DEPTH(2)) m_if ();

  sdp_triosy_multi_wait_dp #(.NUM_CH(4), .DATA_W(8), .DEPTH(2), .MODE(0)) u_queue (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (q_if)
  );

  sdp_triosy_multi_wait_dp #(.NUM_CH(2), .DATA_W(8), .DEPTH(2), .MODE(1)) u_merge (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (m_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    q_if.biwt = '0; q_if.bdwt = '0; q_if.din = '0; q_if.ovf_clr = '0;
    m_if.biwt = '0; m_if.bdwt = '0; m_if.din = '0; m_if.ovf_clr = '0;
    #2;

    // Reset: outputs are pure bypass of the inputs
    q_if.biwt = 4'b0101; q_if.din = 32'hDEADBEEF; #1;
    chk("rst_bawt_bypass", q_if.bawt, 4'b0101);
    chk("rst_dout_bypass", q_if.dout, 32'hDEADBEEF);
    chk("rst_all_bawt", q_if.all_bawt, 1'b0);
    chk("rst_pend", q_if.pend_cnt, 8'h00);
    q_if.biwt = '0; q_if.din = '0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("idle_bawt", q_if.bawt, 4'b0000);
    chk("idle_all_bawt", q_if.all_bawt, 1'b0);
    chk("idle_pend", q_if.pend_cnt, 8'h00);
    chk("idle_ovf", q_if.ovf, 4'b0000);

    // Bypass on ch0
    tick();
    q_if.biwt = 4'b0001; q_if.din = 32'h0000_005A; q_if.bdwt = 4'b0001; #1;
    chk("byp_bawt", q_if.bawt, 4'b0001);
    chk("byp_dout", q_if.dout[7:0], 8'h5A);
    tick();
    q_if.biwt = '0; q_if.din = '0; q_if.bdwt = '0; #1;
    chk("byp_pend", q_if.pend_cnt, 8'h00);
    chk("byp_bawt_after", q_if.bawt, 4'b0000);

    // Queue order and overflow on ch1
    q_if.biwt = 4'b0010; q_if.din = 32'h0000_1100;
    tick();
    q_if.din = 32'h0000_2200;
    tick();
    q_if.din = 32'h0000_3300; #1;
    chk("q1_pend_full", q_if.pend_cnt[3:2], 2'd2);
    chk("q1_head_while_full", q_if.dout[15:8], 8'h11);
    tick();
    q_if.biwt = '0; q_if.din = '0; #1;
    chk("q1_ovf_set", q_if.ovf, 4'b0010);
    chk("q1_pend_after_drop", q_if.pend_cnt[3:2], 2'd2);
    q_if.bdwt = 4'b0010; #1;
    chk("q1_take0", q_if.dout[15:8], 8'h11);
    tick();
    chk("q1_take1", q_if.dout[15:8], 8'h22);
    chk("q1_pend_one", q_if.pend_cnt[3:2], 2'd1);
    tick();
    q_if.bdwt = '0; #1;
    chk("q1_pend_empty", q_if.pend_cnt[3:2], 2'd0);
    chk("q1_bawt_empty", q_if.bawt[1], 1'b0);
    q_if.ovf_clr = 4'b0010;
    tick();
    q_if.ovf_clr = '0; #1;
    chk("q1_ovf_clr", q_if.ovf, 4'b0000);

    // Full queue with simultaneous push and take on ch2
    q_if.biwt = 4'b0100; q_if.din = 32'h00A0_0000;
    tick();
    q_if.din = 32'h00A1_0000;
    tick();
    q_if.din = 32'h00A2_0000; q_if.bdwt = 4'b0100; #1;
    chk("q2_pend_full", q_if.pend_cnt[5:4], 2'd2);
    chk("q2_head_a0", q_if.dout[23:16], 8'hA0);
    tick();
    q_if.biwt = '0; q_if.din = '0; #1;
    chk("q2_pend_kept", q_if.pend_cnt[5:4], 2'd2);
    chk("q2_no_ovf", q_if.ovf, 4'b0000);
    chk("q2_head_a1", q_if.dout[23:16], 8'hA1);
    tick();
    chk("q2_head_a2", q_if.dout[23:16], 8'hA2);
    chk("q2_pend_one", q_if.pend_cnt[5:4], 2'd1);
    tick();
    q_if.bdwt = '0; #1;
    chk("q2_pend_empty", q_if.pend_cnt[5:4], 2'd0);

    // Reset mid-operation on a full ch3
    q_if.biwt = 4'b1000; q_if.din = 32'h7700_0000;
    tick(); tick();
    q_if.biwt = '0; q_if.din = '0; #1;
    chk("q3_pend_full", q_if.pend_cnt[7:6], 2'd2);
    chk("q3_bawt_held", q_if.bawt, 4'b1000);
    rst = 1'b1; #1;
    chk("q3_rst_pend", q_if.pend_cnt, 8'h00);
    chk("q3_rst_bawt", q_if.bawt, 4'b0000);
    chk("q3_rst_ovf", q_if.ovf, 4'b0000);
    tick();
    rst = 1'b0;

    // Aggregate availability
    q_if.biwt = 4'b0111; q_if.bdwt = 4'b0111; #1;
    chk("agg_three", q_if.all_bawt, 1'b0);
    q_if.biwt = 4'b1111; q_if.bdwt = 4'b1111; #1;
    chk("agg_four", q_if.all_bawt, 1'b1);
    tick();
    q_if.biwt = '0; q_if.bdwt = '0; #1;
    chk("agg_pend", q_if.pend_cnt, 8'h00);

    // MERGE instance, channel 0
    m_if.biwt = 2'b01; m_if.din = 16'h0001;
    tick();
    m_if.biwt = '0; m_if.din = '0; #1;
    chk("m_v_first", m_if.pend_cnt[1:0], 2'd1);
    chk("m_dout_first", m_if.dout[7:0], 8'h01);
    chk("m_ovf_first", m_if.ovf, 2'b00);
    m_if.biwt = 2'b01; m_if.din = 16'h0002; #1;
    chk("m_dout_bypass", m_if.dout[7:0], 8'h02);
    tick();
    m_if.biwt = '0; m_if.din = '0; #1;
    chk("m_v_merged", m_if.pend_cnt[1:0], 2'd1);
    chk("m_dout_latest", m_if.dout[7:0], 8'h02);
    chk("m_ovf_merged", m_if.ovf, 2'b01);
    m_if.bdwt = 2'b01; #1;
    chk("m_bawt_held", m_if.bawt, 2'b01);
    tick();
    m_if.bdwt = '0; #1;
    chk("m_v_taken", m_if.pend_cnt[1:0], 2'd0);
    chk("m_bawt_taken", m_if.bawt, 2'b00);
    m_if.biwt = 2'b01; m_if.din = 16'h0003;
    tick();
    m_if.din = 16'h0004; m_if.ovf_clr = 2'b01;
    tick();
    m_if.biwt = '0; m_if.din = '0; m_if.ovf_clr = '0; #1;
    chk("m_ovf_set_priority", m_if.ovf, 2'b01);
    chk("m_dout_after_clr", m_if.dout[7:0], 8'h04);
    m_if.ovf_clr = 2'b01;
    tick();
    m_if.ovf_clr = '0; #1;
    chk("m_ovf_cleared", m_if.ovf, 2'b00);
    chk("m_v_still_held", m_if.pend_cnt[1:0], 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
